// File: rtl/mem_stage_if.sv
// Bus bundle for the memory stage: EX-side inputs, pipeline controls,
// the data-memory port, the writeback outputs and the access counters.
interface mem_stage_if;
  logic        e_valid;
  logic [3:0]  e_op;
  logic [31:0] e_addr;
  logic [31:0] e_wdata;
  logic [31:0] e_pc;
  logic [4:0]  e_rd;
  logic        hold;
  logic        flush;

  logic [31:0] dm_A;
  logic [31:0] dm_WD;
  logic        dm_WE;
  logic [3:0]  dm_BE;
  logic [31:0] dm_pc;
  logic [31:0] dm_RD;

  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic        wb_exc;
  logic [4:0]  wb_exc_code;

  logic [31:0] ld_cnt;
  logic [31:0] st_cnt;

  modport slave (
    input  e_valid, e_op, e_addr, e_wdata, e_pc, e_rd, hold, flush, dm_RD,
    output dm_A, dm_WD, dm_WE, dm_BE, dm_pc,
    output wb_valid, wb_we, wb_rd, wb_data, wb_pc, wb_exc, wb_exc_code,
    output ld_cnt, st_cnt
  );

  modport master (
    output e_valid, e_op, e_addr, e_wdata, e_pc, e_rd, hold, flush, dm_RD,
    input  dm_A, dm_WD, dm_WE, dm_BE, dm_pc,
    input  wb_valid, wb_we, wb_rd, wb_data, wb_pc, wb_exc, wb_exc_code,
    input  ld_cnt, st_cnt
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: M register drives the data-memory port, loads are
// extracted/extended into the W register, misaligned accesses raise exceptions.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  bus
);

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LW   = 4'd1,
    OP_LH   = 4'd2,
    OP_LHU  = 4'd3,
    OP_LB   = 4'd4,
    OP_LBU  = 4'd5,
    OP_SW   = 4'd6,
    OP_SH   = 4'd7,
    OP_SB   = 4'd8
  } op_e;

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [4:0]  rd;
  } m_reg_t;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
    logic        exc;
    logic [4:0]  exc_code;
  } w_reg_t;

  m_reg_t      r_m;
  w_reg_t      r_w;
  logic [31:0] r_ld_cnt;
  logic [31:0] r_st_cnt;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_misaligned;
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  logic [31:0] w_ld_data;
  logic        w_acc_ok;
  logic        w_dm_we;
  logic        w_ld_fire;

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values; reset is synchronous and outranks flush and hold.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      r_m <= '0;
    end else if (!bus.hold) begin
      r_m <= '{valid: bus.e_valid, op: bus.e_op, addr: bus.e_addr,
               wdata: bus.e_wdata, pc: bus.e_pc, rd: bus.e_rd};
    end
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    w_is_load    = 1'b0;
    w_is_store   = 1'b0;
    w_misaligned = 1'b0;
    w_be         = 4'b0000;
    w_wd         = r_m.wdata;
    case (r_m.op)
      OP_LW: begin
        w_is_load    = 1'b1;
        w_misaligned = |r_m.addr[1:0];
      end
      OP_LH, OP_LHU: begin
        w_is_load    = 1'b1;
        w_misaligned = r_m.addr[0];
      end
      OP_LB, OP_LBU: w_is_load = 1'b1;
      OP_SW: begin
        w_is_store   = 1'b1;
        w_misaligned = |r_m.addr[1:0];
        w_be         = 4'b1111;
      end
      OP_SH: begin
        w_is_store   = 1'b1;
        w_misaligned = r_m.addr[0];
        w_be         = r_m.addr[1] ? 4'b1100 : 4'b0011;
        w_wd         = {2{r_m.wdata[15:0]}};
      end
      OP_SB: begin
        w_is_store   = 1'b1;
        w_be         = 4'b0001 << r_m.addr[1:0];
        w_wd         = {4{r_m.wdata[7:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection out of the word read at dm_A.
  assign w_half = r_m.addr[1] ? bus.dm_RD[31:16] : bus.dm_RD[15:0];

  always_comb begin
    w_byte = bus.dm_RD[7:0];
    case (r_m.addr[1:0])
      2'd1:    w_byte = bus.dm_RD[15:8];
      2'd2:    w_byte = bus.dm_RD[23:16];
      2'd3:    w_byte = bus.dm_RD[31:24];
      default: w_byte = bus.dm_RD[7:0];
    endcase
  end

  always_comb begin
    w_ld_data = '0;
    case (r_m.op)
      OP_LW:   w_ld_data = bus.dm_RD;
      OP_LH:   w_ld_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_ld_data = {16'h0000, w_half};
      OP_LB:   w_ld_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_ld_data = {24'h000000, w_byte};
      default: w_ld_data = '0;
    endcase
  end

  assign w_acc_ok  = r_m.valid && !w_misaligned;
  assign w_dm_we   = w_acc_ok && w_is_store && !bus.hold;
  assign w_ld_fire = w_acc_ok && w_is_load && !bus.hold;

  assign bus.dm_A  = r_m.addr;
  assign bus.dm_pc = r_m.pc;
  assign bus.dm_WD = w_wd;
  assign bus.dm_WE = w_dm_we;
  assign bus.dm_BE = r_m.valid ? w_be : 4'b0000;

  // A held M slot is not retired, so W sees a bubble for each hold cycle.
  always_ff @(posedge clk) begin
    if (reset || bus.hold) begin
      r_w <= '0;
    end else begin
      r_w.valid    <= r_m.valid;
      r_w.we       <= w_acc_ok && w_is_load && (r_m.rd != 5'd0);
      r_w.rd       <= r_m.rd;
      r_w.data     <= w_is_load ? w_ld_data : 32'h0;
      r_w.pc       <= r_m.pc;
      r_w.exc      <= r_m.valid && w_misaligned;
      r_w.exc_code <= (r_m.valid && w_misaligned) ? (w_is_store ? 5'd5 : 5'd4) : 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ld_cnt <= '0;
      r_st_cnt <= '0;
    end else begin
      if (w_ld_fire && (r_ld_cnt != 32'hFFFF_FFFF)) r_ld_cnt <= r_ld_cnt + 32'd1;
      if (w_dm_we && (r_st_cnt != 32'hFFFF_FFFF))   r_st_cnt <= r_st_cnt + 32'd1;
    end
  end

  assign bus.wb_valid    = r_w.valid;
  assign bus.wb_we       = r_w.we;
  assign bus.wb_rd       = r_w.rd;
  assign bus.wb_data     = r_w.data;
  assign bus.wb_pc       = r_w.pc;
  assign bus.wb_exc      = r_w.exc;
  assign bus.wb_exc_code = r_w.exc_code;
  assign bus.ld_cnt      = r_ld_cnt;
  assign bus.st_cnt      = r_st_cnt;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stores, load extraction, misalignment,
// hold/flush interplay and reset, each scenario checked inline.
module tb_mem_stage;
  localparam logic [3:0] LW = 4'd1, LH = 4'd2, LHU = 4'd3, LB = 4'd4, LBU = 4'd5;
  localparam logic [3:0] SW = 4'd6, SH = 4'd7, SB = 4'd8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_stage_if bus ();
  mem_stage dut (.clk(clk), .reset(reset), .bus(bus));

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_ld = 0;
  logic [31:0] exp_st = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.e_valid = 1'b0;
    bus.e_op    = 4'd0;
    bus.e_addr  = '0;
    bus.e_wdata = '0;
    bus.e_pc    = '0;
    bus.e_rd    = '0;
  endtask

  // Present one access and clock it into M; EX goes idle afterwards.
  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] pc, input logic [4:0] rd);
    bus.e_valid = 1'b1;
    bus.e_op    = op;
    bus.e_addr  = addr;
    bus.e_wdata = wdata;
    bus.e_pc    = pc;
    bus.e_rd    = rd;
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.hold  = 1'b1;
    bus.flush = 1'b0;
    bus.dm_RD = 32'h0;
    bus.e_valid = 1'b1; bus.e_op = SW; bus.e_addr = 32'h10; bus.e_wdata = 32'h55;
    bus.e_pc = 32'h8; bus.e_rd = 5'd3;
    step();
    step();
    reset = 1'b0;
    bus.hold = 1'b0;
    idle_inputs();
    #1;
    total++; if (bus.dm_A        !== 32'h0) $display("FAIL rst_dm_A got=%h exp=0", bus.dm_A); else passed++;
    total++; if (bus.dm_WD       !== 32'h0) $display("FAIL rst_dm_WD got=%h exp=0", bus.dm_WD); else passed++;
    total++; if (bus.dm_WE       !== 1'b0)  $display("FAIL rst_dm_WE got=%b exp=0", bus.dm_WE); else passed++;
    total++; if (bus.dm_BE       !== 4'h0)  $display("FAIL rst_dm_BE got=%b exp=0000", bus.dm_BE); else passed++;
    total++; if (bus.dm_pc       !== 32'h0) $display("FAIL rst_dm_pc got=%h exp=0", bus.dm_pc); else passed++;
    total++; if (bus.wb_valid    !== 1'b0)  $display("FAIL rst_wb_valid got=%b exp=0", bus.wb_valid); else passed++;
    total++; if (bus.wb_we       !== 1'b0)  $display("FAIL rst_wb_we got=%b exp=0", bus.wb_we); else passed++;
    total++; if (bus.wb_rd       !== 5'd0)  $display("FAIL rst_wb_rd got=%h exp=0", bus.wb_rd); else passed++;
    total++; if (bus.wb_data     !== 32'h0) $display("FAIL rst_wb_data got=%h exp=0", bus.wb_data); else passed++;
    total++; if (bus.wb_pc       !== 32'h0) $display("FAIL rst_wb_pc got=%h exp=0", bus.wb_pc); else passed++;
    total++; if (bus.wb_exc      !== 1'b0)  $display("FAIL rst_wb_exc got=%b exp=0", bus.wb_exc); else passed++;
    total++; if (bus.wb_exc_code !== 5'd0)  $display("FAIL rst_wb_exc_code got=%h exp=0", bus.wb_exc_code); else passed++;
    total++; if (bus.ld_cnt      !== 32'h0) $display("FAIL rst_ld_cnt got=%h exp=0", bus.ld_cnt); else passed++;
    total++; if (bus.st_cnt      !== 32'h0) $display("FAIL rst_st_cnt got=%h exp=0", bus.st_cnt); else passed++;
    exp_ld = 0;
    exp_st = 0;
  endtask

  task automatic test_stores();
    logic [3:0]  ops [3] = '{SB, SH, SW};
    logic [31:0] adr [3] = '{32'h13, 32'h2, 32'h8};
    logic [31:0] wd  [3] = '{32'hAB, 32'h1234_5678, 32'hCAFE_F00D};
    logic [3:0]  be  [3] = '{4'b1000, 4'b1100, 4'b1111};
    logic [31:0] xwd [3] = '{32'hABAB_ABAB, 32'h5678_5678, 32'hCAFE_F00D};
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], adr[i], wd[i], 32'h1000 + 32'(i * 4), 5'd0);
      total++; if (bus.dm_BE !== be[i])  $display("FAIL st%0d_dm_BE got=%b exp=%b", i, bus.dm_BE, be[i]); else passed++;
      total++; if (bus.dm_WD !== xwd[i]) $display("FAIL st%0d_dm_WD got=%h exp=%h", i, bus.dm_WD, xwd[i]); else passed++;
      total++; if (bus.dm_WE !== 1'b1)   $display("FAIL st%0d_dm_WE got=%b exp=1", i, bus.dm_WE); else passed++;
      total++; if (bus.dm_A  !== adr[i]) $display("FAIL st%0d_dm_A got=%h exp=%h", i, bus.dm_A, adr[i]); else passed++;
      step();
      exp_st++;
      total++; if (bus.st_cnt   !== exp_st) $display("FAIL st%0d_st_cnt got=%0d exp=%0d", i, bus.st_cnt, exp_st); else passed++;
      total++; if (bus.wb_valid !== 1'b1)   $display("FAIL st%0d_wb_valid got=%b exp=1", i, bus.wb_valid); else passed++;
      total++; if (bus.wb_we    !== 1'b0)   $display("FAIL st%0d_wb_we got=%b exp=0", i, bus.wb_we); else passed++;
      total++; if (bus.wb_data  !== 32'h0)  $display("FAIL st%0d_wb_data got=%h exp=0", i, bus.wb_data); else passed++;
    end
  endtask

  task automatic test_loads();
    logic [3:0]  ops [6] = '{LH, LHU, LB, LBU, LB, LW};
    logic [31:0] adr [6] = '{32'h2, 32'h2, 32'h1, 32'h3, 32'h3, 32'h4};
    logic [31:0] rdv [6] = '{32'h8001_1234, 32'h8001_1234, 32'h0000_7F00,
                             32'h8000_0000, 32'h8000_0000, 32'hDEAD_BEEF};
    logic [31:0] xd  [6] = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_007F,
                             32'h0000_0080, 32'hFFFF_FF80, 32'hDEAD_BEEF};
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], adr[i], 32'h0, 32'h2000 + 32'(i * 4), 5'(i + 1));
      bus.dm_RD = rdv[i];
      step();
      exp_ld++;
      total++; if (bus.wb_data !== xd[i])  $display("FAIL ld%0d_wb_data got=%h exp=%h", i, bus.wb_data, xd[i]); else passed++;
      total++; if (bus.wb_we   !== 1'b1)   $display("FAIL ld%0d_wb_we got=%b exp=1", i, bus.wb_we); else passed++;
      total++; if (bus.wb_rd   !== 5'(i + 1)) $display("FAIL ld%0d_wb_rd got=%0d exp=%0d", i, bus.wb_rd, i + 1); else passed++;
      total++; if (bus.wb_pc   !== 32'h2000 + 32'(i * 4)) $display("FAIL ld%0d_wb_pc got=%h", i, bus.wb_pc); else passed++;
      total++; if (bus.ld_cnt  !== exp_ld) $display("FAIL ld%0d_ld_cnt got=%0d exp=%0d", i, bus.ld_cnt, exp_ld); else passed++;
    end
  endtask

  task automatic test_misaligned();
    logic [3:0]  ops [4] = '{SW, LW, SH, LHU};
    logic [31:0] adr [4] = '{32'h6, 32'h1, 32'h1, 32'h3};
    logic [4:0]  code[4] = '{5'd5, 5'd4, 5'd5, 5'd4};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], adr[i], 32'h1111_2222, 32'h3000, 5'd7);
      bus.dm_RD = 32'h1234_5678;
      total++; if (bus.dm_WE !== 1'b0) $display("FAIL mis%0d_dm_WE got=%b exp=0", i, bus.dm_WE); else passed++;
      step();
      total++; if (bus.wb_exc      !== 1'b1)    $display("FAIL mis%0d_wb_exc got=%b exp=1", i, bus.wb_exc); else passed++;
      total++; if (bus.wb_exc_code !== code[i]) $display("FAIL mis%0d_code got=%0d exp=%0d", i, bus.wb_exc_code, code[i]); else passed++;
      total++; if (bus.wb_we       !== 1'b0)    $display("FAIL mis%0d_wb_we got=%b exp=0", i, bus.wb_we); else passed++;
      total++; if (bus.st_cnt      !== exp_st)  $display("FAIL mis%0d_st_cnt got=%0d exp=%0d", i, bus.st_cnt, exp_st); else passed++;
      total++; if (bus.ld_cnt      !== exp_ld)  $display("FAIL mis%0d_ld_cnt got=%0d exp=%0d", i, bus.ld_cnt, exp_ld); else passed++;
    end
    // aligned byte load at an odd address clears the exception
    issue(LB, 32'h3, 32'h0, 32'h3010, 5'd8);
    step();
    exp_ld++;
    total++; if (bus.wb_exc      !== 1'b0) $display("FAIL lb_odd_wb_exc got=%b exp=0", bus.wb_exc); else passed++;
    total++; if (bus.wb_exc_code !== 5'd0) $display("FAIL lb_odd_code got=%0d exp=0", bus.wb_exc_code); else passed++;
    total++; if (bus.wb_data !== 32'h0000_0012) $display("FAIL lb_odd_data got=%h exp=00000012", bus.wb_data); else passed++;
  endtask

  task automatic test_hold();
    issue(SH, 32'h22, 32'h0000_BEEF, 32'h4000, 5'd0);
    bus.hold = 1'b1;
    #1;
    total++; if (bus.dm_WE !== 1'b0) $display("FAIL hold0_dm_WE got=%b exp=0", bus.dm_WE); else passed++;
    for (int i = 1; i <= 2; i++) begin
      step();
      total++; if (bus.wb_valid !== 1'b0)   $display("FAIL hold%0d_wb_valid got=%b exp=0", i, bus.wb_valid); else passed++;
      total++; if (bus.dm_WE    !== 1'b0)   $display("FAIL hold%0d_dm_WE got=%b exp=0", i, bus.dm_WE); else passed++;
      total++; if (bus.st_cnt   !== exp_st) $display("FAIL hold%0d_st_cnt got=%0d exp=%0d", i, bus.st_cnt, exp_st); else passed++;
      total++; if (bus.dm_A     !== 32'h22) $display("FAIL hold%0d_dm_A got=%h exp=22", i, bus.dm_A); else passed++;
    end
    bus.hold = 1'b0;
    #1;
    total++; if (bus.dm_WE !== 1'b1)         $display("FAIL hold_rel_dm_WE got=%b exp=1", bus.dm_WE); else passed++;
    total++; if (bus.dm_BE !== 4'b1100)      $display("FAIL hold_rel_dm_BE got=%b exp=1100", bus.dm_BE); else passed++;
    total++; if (bus.dm_WD !== 32'hBEEF_BEEF) $display("FAIL hold_rel_dm_WD got=%h exp=BEEFBEEF", bus.dm_WD); else passed++;
    step();
    exp_st++;
    total++; if (bus.st_cnt   !== exp_st)    $display("FAIL hold_done_st_cnt got=%0d exp=%0d", bus.st_cnt, exp_st); else passed++;
    total++; if (bus.wb_valid !== 1'b1)      $display("FAIL hold_done_wb_valid got=%b exp=1", bus.wb_valid); else passed++;
    total++; if (bus.wb_pc    !== 32'h4000)  $display("FAIL hold_done_wb_pc got=%h exp=4000", bus.wb_pc); else passed++;
    total++; if (bus.dm_WE    !== 1'b0)      $display("FAIL hold_done_dm_WE got=%b exp=0", bus.dm_WE); else passed++;
    step();
    total++; if (bus.st_cnt   !== exp_st)    $display("FAIL hold_once_st_cnt got=%0d exp=%0d", bus.st_cnt, exp_st); else passed++;
  endtask

  task automatic test_flush();
    bus.hold  = 1'b1;
    bus.flush = 1'b1;
    issue(LW, 32'h20, 32'h0, 32'h5000, 5'd3);
    total++; if (bus.dm_A  !== 32'h0) $display("FAIL flush_dm_A got=%h exp=0", bus.dm_A); else passed++;
    total++; if (bus.dm_BE !== 4'h0)  $display("FAIL flush_dm_BE got=%b exp=0000", bus.dm_BE); else passed++;
    bus.hold  = 1'b0;
    bus.flush = 1'b0;
    bus.dm_RD = 32'hFFFF_FFFF;
    step();
    total++; if (bus.wb_valid !== 1'b0)   $display("FAIL flush_wb_valid got=%b exp=0", bus.wb_valid); else passed++;
    total++; if (bus.wb_we    !== 1'b0)   $display("FAIL flush_wb_we got=%b exp=0", bus.wb_we); else passed++;
    total++; if (bus.ld_cnt   !== exp_ld) $display("FAIL flush_ld_cnt got=%0d exp=%0d", bus.ld_cnt, exp_ld); else passed++;
  endtask

  task automatic test_back_to_back();
    bus.e_valid = 1'b1; bus.e_op = LW; bus.e_addr = 32'h40; bus.e_wdata = 32'h0;
    bus.e_pc = 32'h6000; bus.e_rd = 5'd0;
    step();
    bus.dm_RD = 32'h1111_2222;
    bus.e_valid = 1'b1; bus.e_op = SW; bus.e_addr = 32'h44; bus.e_wdata = 32'h55;
    bus.e_pc = 32'h6004; bus.e_rd = 5'd0;
    step();
    exp_ld++;
    total++; if (bus.wb_valid !== 1'b1)        $display("FAIL b2b_wb_valid got=%b exp=1", bus.wb_valid); else passed++;
    total++; if (bus.wb_we    !== 1'b0)        $display("FAIL b2b_wb_we got=%b exp=0", bus.wb_we); else passed++;
    total++; if (bus.wb_data  !== 32'h1111_2222) $display("FAIL b2b_wb_data got=%h exp=11112222", bus.wb_data); else passed++;
    total++; if (bus.wb_pc    !== 32'h6000)    $display("FAIL b2b_wb_pc got=%h exp=6000", bus.wb_pc); else passed++;
    total++; if (bus.ld_cnt   !== exp_ld)      $display("FAIL b2b_ld_cnt got=%0d exp=%0d", bus.ld_cnt, exp_ld); else passed++;
    total++; if (bus.dm_WE    !== 1'b1)        $display("FAIL b2b_dm_WE got=%b exp=1", bus.dm_WE); else passed++;
    total++; if (bus.dm_A     !== 32'h44)      $display("FAIL b2b_dm_A got=%h exp=44", bus.dm_A); else passed++;
    total++; if (bus.dm_pc    !== 32'h6004)    $display("FAIL b2b_dm_pc got=%h exp=6004", bus.dm_pc); else passed++;
    // reset lands while the store sits in M and a byte store waits in EX
    bus.e_valid = 1'b1; bus.e_op = SB; bus.e_addr = 32'h45; bus.e_wdata = 32'h77;
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle_inputs();
    #1;
    exp_ld = 0;
    exp_st = 0;
    total++; if (bus.dm_WE    !== 1'b0)  $display("FAIL mrst_dm_WE got=%b exp=0", bus.dm_WE); else passed++;
    total++; if (bus.dm_BE    !== 4'h0)  $display("FAIL mrst_dm_BE got=%b exp=0000", bus.dm_BE); else passed++;
    total++; if (bus.dm_A     !== 32'h0) $display("FAIL mrst_dm_A got=%h exp=0", bus.dm_A); else passed++;
    total++; if (bus.wb_valid !== 1'b0)  $display("FAIL mrst_wb_valid got=%b exp=0", bus.wb_valid); else passed++;
    total++; if (bus.wb_data  !== 32'h0) $display("FAIL mrst_wb_data got=%h exp=0", bus.wb_data); else passed++;
    total++; if (bus.ld_cnt   !== exp_ld) $display("FAIL mrst_ld_cnt got=%0d exp=0", bus.ld_cnt); else passed++;
    total++; if (bus.st_cnt   !== exp_st) $display("FAIL mrst_st_cnt got=%0d exp=0", bus.st_cnt); else passed++;
  endtask

  initial begin
    idle_inputs();
    bus.hold  = 1'b0;
    bus.flush = 1'b0;
    bus.dm_RD = 32'h0;
    reset     = 1'b1;
    test_reset();
    test_stores();
    test_loads();
    test_misaligned();
    test_hold();
    test_flush();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
